// File: rtl/pipe_ctrl.sv
// Pipeline control: stall/bubble arbitration, exception flush-and-redirect sequencing,
// stall performance counter and a sticky watchdog for PC stalls that never clear.
module pipe_ctrl #(
    parameter int NSTAGE    = 5,
    parameter int FLUSH_CYC = 1,
    parameter int WDOG_CYC  = 1024,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stallreq,
    input  logic              excp_valid,
    input  logic [31:0]       excp_target,
    output logic [NSTAGE:0]   stall,
    output logic [NSTAGE-1:0] bubble,
    output logic [NSTAGE-1:0] flush,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic              stall_timeout
);

    typedef enum logic [1:0] {RUN, FLUSH, REDIRECT} state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        flush_cnt;
    logic [31:0]       target;
    logic [NSTAGE:0]   arb_stall;
    logic [NSTAGE-1:0] arb_bubble;
    logic              any_req;
    logic              stall_run;
    int                h;

    // The most downstream requester wins: everything upstream of it freezes and
    // the register just after it takes a bubble.
    always_comb begin
        any_req    = |stallreq;
        h          = 0;
        arb_stall  = '0;
        arb_bubble = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            if (stallreq[k]) h = k;
        end
        if (any_req) begin
            for (int j = 0; j <= NSTAGE; j++) arb_stall[j] = (j <= h + 1);
            for (int k = 0; k < NSTAGE; k++) arb_bubble[k] = (k == h + 1);
        end
    end

    always_comb begin
        state_next     = state;
        stall          = '0;
        bubble         = '0;
        flush          = '0;
        redirect_valid = 1'b0;
        case (state)
            RUN: begin
                stall  = arb_stall;
                bubble = arb_bubble;
            end
            FLUSH: begin
                flush = '1;
                if (flush_cnt <= 4'd1) state_next = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                state_next     = RUN;
            end
            default: state_next = RUN;
        endcase
        if (excp_valid) state_next = FLUSH;
    end

    // A fresh exception always restarts the flush and overwrites the target.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            flush_cnt   <= '0;
            target      <= '0;
            redirect_pc <= '0;
        end else begin
            state <= state_next;
            if (excp_valid) begin
                target    <= excp_target;
                flush_cnt <= 4'(FLUSH_CYC);
            end else if (state == FLUSH) begin
                flush_cnt <= flush_cnt - 4'd1;
            end
            if (state == FLUSH && state_next == REDIRECT) redirect_pc <= target;
        end
    end

    assign stall_run = (state == RUN) && stall[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (stall_run) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    generate
        if (WDOG_CYC > 0) begin : g_wdog
            localparam int WDOG_W = $clog2(WDOG_CYC + 1);
            logic [WDOG_W-1:0] wdog_cnt;

            // Only an unbroken run of PC stalls counts; any gap or flush starts over.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    wdog_cnt      <= '0;
                    stall_timeout <= 1'b0;
                end else if (excp_valid || !stall_run) begin
                    wdog_cnt <= '0;
                end else if (wdog_cnt != WDOG_W'(WDOG_CYC)) begin
                    wdog_cnt <= wdog_cnt + WDOG_W'(1);
                    if (wdog_cnt == WDOG_W'(WDOG_CYC - 1)) stall_timeout <= 1'b1;
                end
            end
        end else begin : g_no_wdog
            assign stall_timeout = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected outputs are queued per step and compared
// against the DUT a moment after the inputs settle.
module tb_pipe_ctrl;

    localparam int NSTAGE    = 5;
    localparam int FLUSH_CYC = 2;
    localparam int WDOG_CYC  = 4;
    localparam int CNT_W     = 4;

    localparam logic [31:0] TGT_A = 32'hBFC00380;
    localparam logic [31:0] TGT_B = 32'h80000180;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NSTAGE-1:0] stallreq = '0;
    logic              excp_valid = 1'b0;
    logic [31:0]       excp_target = '0;
    logic [NSTAGE:0]   stall;
    logic [NSTAGE-1:0] bubble;
    logic [NSTAGE-1:0] flush;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic [CNT_W-1:0]  stall_cycles;
    logic              stall_timeout;

    typedef struct {
        logic [5:0]  stall;
        logic [4:0]  bubble;
        logic [4:0]  flush;
        logic        rv;
        logic [31:0] rpc;
        logic [3:0]  cnt;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    pipe_ctrl #(
        .NSTAGE(NSTAGE), .FLUSH_CYC(FLUSH_CYC), .WDOG_CYC(WDOG_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .stallreq(stallreq), .excp_valid(excp_valid),
        .excp_target(excp_target), .stall(stall), .bubble(bubble), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input string field,
                       input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, observed, expected);
        end
    endtask

    task automatic check_output(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL %s.scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            cmp(tag, "stall",          32'(stall),          32'(e.stall));
            cmp(tag, "bubble",         32'(bubble),         32'(e.bubble));
            cmp(tag, "flush",          32'(flush),          32'(e.flush));
            cmp(tag, "redirect_valid", 32'(redirect_valid), 32'(e.rv));
            cmp(tag, "redirect_pc",    redirect_pc,         e.rpc);
            cmp(tag, "stall_cycles",   32'(stall_cycles),   32'(e.cnt));
            cmp(tag, "stall_timeout",  32'(stall_timeout),  32'(e.to));
        end
    endtask

    task automatic expect_out(input logic [5:0] e_stall, input logic [4:0] e_bubble,
                              input logic [4:0] e_flush, input logic e_rv,
                              input logic [31:0] e_rpc, input logic [3:0] e_cnt,
                              input logic e_to);
        sb.push_back('{stall: e_stall, bubble: e_bubble, flush: e_flush, rv: e_rv,
                       rpc: e_rpc, cnt: e_cnt, to: e_to});
    endtask

    task automatic apply_stimulus(input string tag, input logic [4:0] sr, input logic ev,
                                  input logic [31:0] tgt, input logic [5:0] e_stall,
                                  input logic [4:0] e_bubble, input logic [4:0] e_flush,
                                  input logic e_rv, input logic [31:0] e_rpc,
                                  input logic [3:0] e_cnt, input logic e_to);
        @(negedge clk);
        stallreq    = sr;
        excp_valid  = ev;
        excp_target = tgt;
        expect_out(e_stall, e_bubble, e_flush, e_rv, e_rpc, e_cnt, e_to);
        #1;
        check_output(tag);
    endtask

    initial begin
        #3;
        expect_out('0, '0, '0, 1'b0, '0, 4'd0, 1'b0);
        check_output("reset");
        @(negedge clk);
        rst = 1'b1;

        apply_stimulus("idle",     5'b00000, 0, 0, 6'b000000, 5'b00000, 5'b00000, 0, 0, 4'd0, 0);
        apply_stimulus("ex_hold1", 5'b00100, 0, 0, 6'b001111, 5'b01000, 5'b00000, 0, 0, 4'd0, 0);
        apply_stimulus("ex_hold2", 5'b00100, 0, 0, 6'b001111, 5'b01000, 5'b00000, 0, 0, 4'd1, 0);
        apply_stimulus("id_ex",    5'b00110, 0, 0, 6'b001111, 5'b01000, 5'b00000, 0, 0, 4'd2, 0);
        apply_stimulus("release",  5'b00000, 0, 0, 6'b000000, 5'b00000, 5'b00000, 0, 0, 4'd3, 0);
        apply_stimulus("wb",       5'b10000, 0, 0, 6'b111111, 5'b00000, 5'b00000, 0, 0, 4'd3, 0);
        apply_stimulus("if",       5'b00001, 0, 0, 6'b000011, 5'b00010, 5'b00000, 0, 0, 4'd4, 0);
        apply_stimulus("mem",      5'b01000, 0, 0, 6'b011111, 5'b10000, 5'b00000, 0, 0, 4'd5, 0);
        apply_stimulus("wd_gap",   5'b00000, 0, 0, 6'b000000, 5'b00000, 5'b00000, 0, 0, 4'd6, 0);

        apply_stimulus("excp_a",     5'b00010, 1, TGT_A, 6'b000111, 5'b00100, 5'b00000, 0, 0, 4'd6, 0);
        apply_stimulus("flush_a1",   5'b00010, 0, 0, 6'b000000, 5'b00000, 5'b11111, 0, 0, 4'd7, 0);
        apply_stimulus("flush_a2",   5'b00010, 0, 0, 6'b000000, 5'b00000, 5'b11111, 0, 0, 4'd7, 0);
        apply_stimulus("redirect_a", 5'b00010, 0, 0, 6'b000000, 5'b00000, 5'b00000, 1, TGT_A, 4'd7, 0);
        apply_stimulus("run_after",  5'b00010, 0, 0, 6'b000111, 5'b00100, 5'b00000, 0, TGT_A, 4'd7, 0);

        apply_stimulus("excp_first",  5'b00000, 1, 32'h12345678, 6'b0, 5'b0, 5'b00000, 0, TGT_A, 4'd8, 0);
        apply_stimulus("excp_second", 5'b00000, 1, TGT_B, 6'b0, 5'b0, 5'b11111, 0, TGT_A, 4'd8, 0);
        apply_stimulus("flush_b1",    5'b00000, 0, 0, 6'b0, 5'b0, 5'b11111, 0, TGT_A, 4'd8, 0);
        apply_stimulus("flush_b2",    5'b00000, 0, 0, 6'b0, 5'b0, 5'b11111, 0, TGT_A, 4'd8, 0);
        apply_stimulus("redirect_b",  5'b00000, 0, 0, 6'b0, 5'b0, 5'b00000, 1, TGT_B, 4'd8, 0);
        apply_stimulus("idle_b",      5'b00000, 0, 0, 6'b0, 5'b0, 5'b00000, 0, TGT_B, 4'd8, 0);

        for (int i = 0; i < 4; i++)
            apply_stimulus("wd_hold", 5'b00010, 0, 0, 6'b000111, 5'b00100, 5'b0, 0, TGT_B, 4'(8 + i), 0);
        apply_stimulus("wd_tripped", 5'b00000, 0, 0, 6'b0, 5'b0, 5'b0, 0, TGT_B, 4'd12, 1);
        apply_stimulus("wd_sticky",  5'b00000, 0, 0, 6'b0, 5'b0, 5'b0, 0, TGT_B, 4'd12, 1);

        for (int i = 0; i < 4; i++)
            apply_stimulus("cnt_climb", 5'b00010, 0, 0, 6'b000111, 5'b00100, 5'b0, 0, TGT_B, 4'(12 + i), 1);
        apply_stimulus("cnt_wrap", 5'b00000, 0, 0, 6'b0, 5'b0, 5'b0, 0, TGT_B, 4'd0, 1);

        apply_stimulus("excp_c",  5'b00000, 1, 32'hDEADBEEF, 6'b0, 5'b0, 5'b00000, 0, TGT_B, 4'd0, 1);
        apply_stimulus("flush_c", 5'b00000, 0, 0, 6'b0, 5'b0, 5'b11111, 0, TGT_B, 4'd0, 1);
        #1;
        rst = 1'b0;
        #1;
        expect_out('0, '0, '0, 1'b0, '0, 4'd0, 1'b0);
        check_output("async_reset");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++)
            apply_stimulus("post_reset", 5'b00000, 0, 0, 6'b0, 5'b0, 5'b0, 0, 0, 4'd0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Parametrised pipeline control unit for the MIPS core, replacing the fixed all-zero stall generator. It arbitrates per-stage stall requests into a (NSTAGE+1)-bit stall vector plus bubble-insert vector. It sequences exception/eret flushes through a small FSM that ends in a one-cycle PC redirect. It also maintains a stall performance counter and a stuck-stall watchdog.

Parameters:
NSTAGE, 5, number of pipeline stages; stage 0=IF, 1=ID, 2=EX, 3=MEM, 4=WB.
FLUSH_CYC, 1, cycles flush is held before redirect; legal 1..15.
WDOG_CYC, 1024, consecutive PC-stall cycles before stall_timeout sets; 0 disables the watchdog.
CNT_W, 32, width of stall_cycles counter.

Ports:
clk  input  1  core clock, rising edge.
rst  input  1  reset, asynchronous, active-low.
stallreq  input  NSTAGE  bit k = stage k requests a hold this cycle.
excp_valid  input  1  exception/eret commit pulse from MEM.
excp_target  input  32  redirect PC accompanying excp_valid.
stall  output  NSTAGE+1  bit 0 = hold PC; bit j (j>=1) = hold pipeline register after stage j-1.
bubble  output  NSTAGE  bit k = register after stage k loads a NOP/invalid this cycle.
flush  output  NSTAGE  bit k = squash stage k contents.
redirect_valid  output  1  one-cycle pulse: IF loads redirect_pc.
redirect_pc  output  32  redirect target.
stall_cycles  output  CNT_W  count of cycles with stall[0]=1 in RUN.
stall_timeout  output  1  sticky watchdog flag.

Behaviour:
- Reset (rst=0, asynchronous): state=RUN; target register=0; stall_cycles=0; watchdog count=0; stall_timeout=0. Outputs stall=0, bubble=0, flush=0, redirect_valid=0, redirect_pc=0.
- FSM states: RUN, FLUSH, REDIRECT.
- Stall arbitration (RUN only), combinational, same cycle as stallreq:
  - h = highest set index in stallreq.
  - stall[h+1:0]=1; all other stall bits 0.
  - bubble[h+1]=1 if h<NSTAGE-1; all other bubble bits 0.
  - stallreq=0 gives stall=0 and bubble=0.
  - A downstream request subsumes all upstream requests.
- Exception sequencing:
  - excp_valid=1 at an edge, in any state: latch excp_target, load flush counter with FLUSH_CYC, go to FLUSH. A new exception restarts the sequence and the newest target wins.
  - FLUSH: flush=all-ones, stall=0, bubble=0, stallreq ignored. Counter decrements each cycle; after FLUSH_CYC cycles go to REDIRECT.
  - REDIRECT: exactly one cycle. redirect_valid=1, redirect_pc=latched target, flush=0, stall=0; then RUN.
  - redirect_pc holds its last value outside REDIRECT.
  - Latency: excp_valid sampled at edge t gives flush high for cycles t+1..t+FLUSH_CYC and redirect_valid at cycle t+FLUSH_CYC+1.
- stall_cycles:
  - Increments at each edge where state=RUN and stall[0]=1.
  - Wraps modulo 2^CNT_W.
  - Not incremented in FLUSH or REDIRECT.
- Watchdog:
  - Run counter increments while state=RUN and stall[0]=1; cleared otherwise, including on entering FLUSH.
  - Saturates at WDOG_CYC.
  - When it reaches WDOG_CYC, stall_timeout sets on that edge and stays set until reset. It does not affect stall generation.
  - WDOG_CYC=0: stall_timeout is constant 0.
- Reset mid-FLUSH: immediate return to RUN with all outputs at reset values; the pending redirect is lost.

Test Plan:
- Reset then stallreq=5'b00100 (EX) -> stall=6'b001111, bubble=5'b01000, flush=0; stall_cycles increments by 1 per cycle held.
- stallreq=5'b00110 -> same as EX-only (stall=6'b001111, bubble=5'b01000); stallreq=5'b10000 -> stall=6'b111111, bubble=0.
- FLUSH_CYC=2, excp_valid pulse with target 0xBFC00380 at edge t while stallreq=5'b00010 -> flush=5'b11111 and stall=0 in cycles t+1..t+2; redirect_valid=1 with redirect_pc=0xBFC00380 in cycle t+3; then RUN honours stallreq again.
- Second excp_valid (target 0x80000180) during FLUSH -> counter restarts, redirect_pc=0x80000180, no redirect for the first target.
- WDOG_CYC=4, stallreq[1] held 4 cycles -> stall_timeout=1 after the 4th edge and stays 1 after stallreq clears; holding 3 cycles, releasing 1 cycle, then holding 3 again -> stall_timeout stays 0.
- rst asserted asynchronously mid-FLUSH -> all outputs 0 immediately; after release redirect_valid never pulses; CNT_W=4 counter wraps from 15 to 0.
